// File: rtl/hsv_pkg.sv
// Shared types, widths and helpers for the HSV -> RGB565 conversion path.
package hsv_pkg;

  localparam int unsigned HSV_W      = 6;
  localparam int unsigned LAT        = 4;
  localparam int unsigned HSV_IN_W   = 3 * HSV_W;
  localparam int unsigned SEC_W      = 3;
  localparam int unsigned HX_W       = 9;
  localparam int unsigned VS_W       = 2 * HSV_W;
  localparam int unsigned VSF_W      = 18;
  localparam int unsigned VSFN_W     = 19;
  localparam int unsigned PROD_SHIFT = 12;
  localparam int unsigned F_ONE      = 64;
  localparam int unsigned HUE_MUL    = 6;
  localparam int unsigned R_W        = 5;
  localparam int unsigned G_W        = 6;
  localparam int unsigned B_W        = 5;
  localparam int unsigned RGB_W      = R_W + G_W + B_W;

  // Hue sectors, 60 degrees each, named by the colours they span.
  typedef enum logic [SEC_W-1:0] {
    SEC_R_Y = 3'd0,
    SEC_Y_G = 3'd1,
    SEC_G_C = 3'd2,
    SEC_C_B = 3'd3,
    SEC_B_M = 3'd4,
    SEC_M_R = 3'd5
  } sector_e;

  typedef struct packed {
    logic [HSV_W-1:0] hue;
    logic [HSV_W-1:0] sat;
    logic [HSV_W-1:0] val;
  } hsv_t;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

  // Drop the LSB of red and blue; undoes the {R5,0} / {B5,0} widening upstream.
  function automatic rgb565_t pack_rgb565(input logic [HSV_W-1:0] r6,
                                          input logic [HSV_W-1:0] g6,
                                          input logic [HSV_W-1:0] b6);
    rgb565_t px;
    px.r = R_W'(r6 >> 1);
    px.g = g6;
    px.b = B_W'(b6 >> 1);
    return px;
  endfunction

endpackage

// File: rtl/hsv_sector_mux.sv
// Combinational (p, q, t, V) -> (r, g, b) select by hue sector.
module hsv_sector_mux
  import hsv_pkg::*;
(
  input  logic [SEC_W-1:0] sector,
  input  logic [HSV_W-1:0] p,
  input  logic [HSV_W-1:0] q,
  input  logic [HSV_W-1:0] t,
  input  logic [HSV_W-1:0] v,
  output logic [HSV_W-1:0] r_c,
  output logic [HSV_W-1:0] g_c,
  output logic [HSV_W-1:0] b_c
);

  // Sector select; unreachable sectors 6/7 fall back to the magenta-red mapping.
  always_comb begin
    r_c = v;
    g_c = p;
    b_c = q;
    case (sector)
      SEC_R_Y: begin r_c = v; g_c = t; b_c = p; end
      SEC_Y_G: begin r_c = q; g_c = v; b_c = p; end
      SEC_G_C: begin r_c = p; g_c = v; b_c = t; end
      SEC_C_B: begin r_c = p; g_c = q; b_c = v; end
      SEC_B_M: begin r_c = t; g_c = p; b_c = v; end
      SEC_M_R: begin r_c = v; g_c = p; b_c = q; end
      default: begin r_c = v; g_c = p; b_c = q; end
    endcase
  end

endmodule

// File: rtl/hsv2rgb.sv
// Four-stage HSV(6/6/6) -> RGB565 converter, one pixel per clock, no backpressure.
module hsv2rgb
  import hsv_pkg::*;
(
  input  logic                cmos_pclk,
  input  logic                rst,
  input  logic [HSV_IN_W-1:0] hsv_in,
  input  logic                hsv_data_valid,
  input  logic                hsv_fram_valid,
  output logic [RGB_W-1:0]    rgb_out,
  output logic                rgb_data_valid,
  output logic                rgb_fram_valid
);

  hsv_t px;
  assign px = hsv_in;

  // Stage 1 combinational terms: hue scaled to sector/fraction, V*S product.
  logic [HX_W-1:0] hx_c;
  assign hx_c = HX_W'(px.hue) * HX_W'(HUE_MUL);

  logic [SEC_W-1:0]  s1_sector;
  logic [HSV_W-1:0]  s1_f;
  logic [VS_W-1:0]   s1_vs;
  logic [HSV_W-1:0]  s1_val;

  logic [SEC_W-1:0]  s2_sector;
  logic [VSF_W-1:0]  s2_vsf;
  logic [VSFN_W-1:0] s2_vsfn;
  logic [HSV_W-1:0]  s2_p;
  logic [HSV_W-1:0]  s2_val;

  logic [SEC_W-1:0]  s3_sector;
  logic [HSV_W-1:0]  s3_p;
  logic [HSV_W-1:0]  s3_q;
  logic [HSV_W-1:0]  s3_t;
  logic [HSV_W-1:0]  s3_val;

  logic [LAT-1:0]    dv_q;
  logic [LAT-1:0]    fv_q;

  logic [HSV_W-1:0]  r_c;
  logic [HSV_W-1:0]  g_c;
  logic [HSV_W-1:0]  b_c;

  // S1: split hue into sector and fraction, form V*S, carry V forward.
  always_ff @(posedge cmos_pclk) begin
    if (rst) begin
      s1_sector <= '0;
      s1_f      <= '0;
      s1_vs     <= '0;
      s1_val    <= '0;
    end else begin
      s1_sector <= hx_c[HX_W-1:HSV_W];
      s1_f      <= hx_c[HSV_W-1:0];
      s1_vs     <= VS_W'(px.val) * VS_W'(px.sat);
      s1_val    <= px.val;
    end
  end

  // S2: V*S*f and V*S*(1-f) products, plus p = V*(1-S).
  always_ff @(posedge cmos_pclk) begin
    if (rst) begin
      s2_sector <= '0;
      s2_vsf    <= '0;
      s2_vsfn   <= '0;
      s2_p      <= '0;
      s2_val    <= '0;
    end else begin
      s2_sector <= s1_sector;
      s2_vsf    <= VSF_W'(s1_vs) * VSF_W'(s1_f);
      s2_vsfn   <= VSFN_W'(s1_vs) * (VSFN_W'(F_ONE) - VSFN_W'(s1_f));
      s2_p      <= s1_val - HSV_W'(s1_vs >> HSV_W);
      s2_val    <= s1_val;
    end
  end

  // S3: q and t; both products are strictly below V << 12, so no underflow.
  always_ff @(posedge cmos_pclk) begin
    if (rst) begin
      s3_sector <= '0;
      s3_p      <= '0;
      s3_q      <= '0;
      s3_t      <= '0;
      s3_val    <= '0;
    end else begin
      s3_sector <= s2_sector;
      s3_p      <= s2_p;
      s3_q      <= s2_val - HSV_W'(s2_vsf >> PROD_SHIFT);
      s3_t      <= s2_val - HSV_W'(s2_vsfn >> PROD_SHIFT);
      s3_val    <= s2_val;
    end
  end

  hsv_sector_mux u_sector_mux (
    .sector (s3_sector),
    .p      (s3_p),
    .q      (s3_q),
    .t      (s3_t),
    .v      (s3_val),
    .r_c    (r_c),
    .g_c    (g_c),
    .b_c    (b_c)
  );

  // S4: register the selected channels packed as RGB565.
  always_ff @(posedge cmos_pclk) begin
    if (rst) begin
      rgb_out <= '0;
    end else begin
      rgb_out <= pack_rgb565(r_c, g_c, b_c);
    end
  end

  // Valid and frame flags ride a delay line matching the data pipeline.
  always_ff @(posedge cmos_pclk) begin
    if (rst) begin
      dv_q <= '0;
      fv_q <= '0;
    end else begin
      dv_q <= {dv_q[LAT-2:0], hsv_data_valid};
      fv_q <= {fv_q[LAT-2:0], hsv_fram_valid};
    end
  end

  assign rgb_data_valid = dv_q[LAT-1];
  assign rgb_fram_valid = fv_q[LAT-1];

endmodule
